// File: rtl/spi_txn_arbiter.sv
// SPI master transaction controller: round-robin arbitration between two requesters,
// one full-duplex MSB-first frame per grant, SCK = CLK/DIV with CPK/CPH mode select.
module spi_txn_arbiter #(
  parameter int DATA_W = 16,
  parameter int DIV    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CPK,
  input  logic              CPH,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DATA0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic              RID,
  output logic              BUSY,
  input  logic              MISO,
  output logic              SCK,
  output logic              CS,
  output logic              MOSI
);

  localparam int H      = DIV / 2;
  localparam int CNT_W  = (H > 1) ? $clog2(H) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SETUP,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [EDGE_W-1:0]   r_edge;
  logic [EDGE_W-1:0]   w_edge_nxt;

  logic                w_start;
  logic                w_load;
  logic                w_lead;
  logic                w_trail;
  logic                w_done;
  logic                w_pick;
  logic                w_cnt_zero;
  logic [DATA_W-1:0]   w_data;

  logic                r_id;
  logic                r_last;
  logic                r_cph;
  logic                r_rx_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_cs;
  logic                r_sck;
  logic                r_mosi;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rid;

  // With both requesting, favour the one not granted last.
  assign w_pick     = (REQ0 && REQ1) ? ~r_last : REQ1;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_data     = r_id ? DATA1 : DATA0;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_edge  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_edge  <= w_edge_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_edge_nxt  = r_edge;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_lead      = 1'b0;
    w_trail     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          w_state_nxt = S_GRANT;
          w_start     = 1'b1;
        end
      end
      S_GRANT: begin
        w_state_nxt = S_SETUP;
        w_load      = 1'b1;
        w_cnt_nxt   = CNT_W'(H - 1);
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_SHIFT;
          w_lead      = 1'b1;
          w_edge_nxt  = EDGE_W'(1);
          w_cnt_nxt   = CNT_W'(H - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (w_cnt_zero) begin
          w_cnt_nxt = CNT_W'(H - 1);
          // The final half-period keeps SCK idle; its end is the CS-rise cycle.
          if (r_edge == EDGE_W'(2 * DATA_W)) begin
            w_state_nxt = S_GAP;
            w_done      = 1'b1;
          end else begin
            w_edge_nxt = r_edge + EDGE_W'(1);
            if (r_edge[0]) w_trail = 1'b1;
            else           w_lead  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (w_cnt_zero) w_state_nxt = S_IDLE;
        else            w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Link-side control: CS, SCK, MOSI, result handshake and arbitration pointer.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_cs     <= 1'b1;
      r_mosi   <= 1'b0;
      r_sck    <= CPK;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= 1'b0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      r_rvalid <= w_done;
      if (w_start) begin
        r_id   <= w_pick;
        r_last <= w_pick;
      end
      if (r_state == S_IDLE || r_state == S_GRANT) r_sck <= CPK;
      if (w_load) begin
        r_cs   <= 1'b0;
        r_mosi <= w_data[DATA_W-1];
      end
      if (w_lead) begin
        r_sck <= ~r_sck;
        if (r_cph) r_mosi <= r_shift[DATA_W-1];
      end
      if (w_trail) begin
        r_sck <= ~r_sck;
        if (!r_cph) r_mosi <= r_shift[DATA_W-2];
      end
      if (w_done) begin
        r_cs    <= 1'b1;
        r_mosi  <= 1'b0;
        r_rdata <= r_shift;
        r_rid   <= r_id;
      end
    end
  end

  // Shift datapath; both modes shift on the trailing edge, CPH=0 uses the leading-edge sample.
  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_shift <= w_data;
      r_cph   <= CPH;
    end
    if (w_lead) r_rx_bit <= MISO;
    if (w_trail) r_shift <= {r_shift[DATA_W-2:0], (r_cph ? MISO : r_rx_bit)};
  end

  assign GNT0   = (r_state == S_GRANT) && !r_id;
  assign GNT1   = (r_state == S_GRANT) &&  r_id;
  assign BUSY   = (r_state != S_IDLE);
  assign CS     = r_cs;
  assign SCK    = r_sck;
  assign MOSI   = r_mosi;
  assign RVALID = r_rvalid;
  assign RDATA  = r_rdata;
  assign RID    = r_rid;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: modes 0/3, round-robin, mid-frame reset,
// latched configuration and withdrawn requests, with frame timing monitored on CS/SCK/MOSI.
module tb_spi_txn_arbiter;

  localparam int DATA_W = 16;
  localparam int DIV    = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              CPK, CPH;
  logic              REQ0, REQ1;
  logic [DATA_W-1:0] DATA0, DATA1;
  logic              GNT0, GNT1;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID, RID, BUSY;
  logic              MISO, SCK, CS, MOSI;
  logic              loop_en;
  logic              miso_val;

  int total = 0;
  int bad   = 0;

  assign MISO = loop_en ? MOSI : miso_val;

  always #5 CLK = ~CLK;

  spi_txn_arbiter #(.DATA_W(DATA_W), .DIV(DIV)) dut (
    .CLK(CLK), .RESET(RESET), .CPK(CPK), .CPH(CPH),
    .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RDATA(RDATA), .RVALID(RVALID),
    .RID(RID), .BUSY(BUSY), .MISO(MISO), .SCK(SCK), .CS(CS), .MOSI(MOSI)
  );

  // Frame monitor sampled on the falling clock edge.
  logic cs_q = 1'b1, sck_q = 1'b0;
  int   rv_cnt = 0, g1_cnt = 0;
  int   low_run = 0, hi_run = 0, rise_run = 0, mosi_hi_run = 0, first_hi = -1;
  int   last_cs_low = 0, last_cs_high = 0, last_rises = 0, last_mosi_hi = 0, last_first_hi = -1;
  logic sck_setup = 1'b0;

  always @(negedge CLK) begin
    cs_q  <= CS;
    sck_q <= SCK;
    if (RVALID) rv_cnt <= rv_cnt + 1;
    if (GNT1)   g1_cnt <= g1_cnt + 1;
    if (!CS) begin
      if (cs_q) begin
        last_cs_high <= hi_run;
        low_run      <= 1;
        rise_run     <= 0;
        mosi_hi_run  <= MOSI ? 1 : 0;
        first_hi     <= MOSI ? 0 : -1;
        sck_setup    <= SCK;
      end else begin
        low_run <= low_run + 1;
        if (SCK && !sck_q) rise_run <= rise_run + 1;
        if (MOSI) begin
          mosi_hi_run <= mosi_hi_run + 1;
          if (first_hi < 0) first_hi <= low_run;
        end
      end
    end else begin
      if (!cs_q) begin
        last_cs_low   <= low_run;
        last_rises    <= rise_run;
        last_mosi_hi  <= mosi_hi_run;
        last_first_hi <= first_hi;
        hi_run        <= 1;
      end else begin
        hi_run <= hi_run + 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget; i++) begin
      if (GNT0) begin who = 0; break; end
      if (GNT1) begin who = 1; break; end
      tick();
    end
  endtask

  task automatic wait_rvalid(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (RVALID) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!BUSY) begin ok = 1; break; end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, ok, rv_save, g1_save;
    logic [DATA_W-1:0] exp_data [2];
    int exp_id [4];

    RESET = 1'b0; CPK = 1'b0; CPH = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; DATA0 = '0; DATA1 = '0;
    loop_en = 1'b1; miso_val = 1'b0;
    tick(2);

    chk("rst_cs", CS, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_gnt", {GNT0, GNT1}, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rid", RID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_sck", SCK, 0);
    RESET = 1'b1;
    tick(2);

    // Mode 0 loopback
    DATA0 = 16'hA5C3; REQ0 = 1'b1;
    wait_gnt(20, who);
    chk("m0_gnt", who, 0);
    REQ0 = 1'b0;
    wait_rvalid(200, ok);
    chk("m0_rvalid", ok, 1);
    chk("m0_rdata", RDATA, 16'hA5C3);
    chk("m0_rid", RID, 0);
    chk("m0_busy_gap", BUSY, 1);
    tick();
    chk("m0_cs_low", last_cs_low, 66);
    chk("m0_sck_rises", last_rises, 16);
    chk("m0_sck_setup", sck_setup, 0);
    wait_idle(20, ok);
    tick();
    chk("m0_sck_idle", SCK, 0);

    // Mode 3, MISO held high
    loop_en = 1'b0; miso_val = 1'b1; CPK = 1'b1; CPH = 1'b1;
    tick(2);
    chk("m3_sck_idle_pre", SCK, 1);
    DATA1 = 16'h0001; REQ1 = 1'b1;
    wait_gnt(20, who);
    chk("m3_gnt", who, 1);
    REQ1 = 1'b0;
    wait_rvalid(200, ok);
    chk("m3_rvalid", ok, 1);
    chk("m3_rdata", RDATA, 16'hFFFF);
    chk("m3_rid", RID, 1);
    tick();
    chk("m3_cs_low", last_cs_low, 66);
    chk("m3_sck_rises", last_rises, 16);
    chk("m3_sck_setup", sck_setup, 1);
    chk("m3_mosi_hi_cycles", last_mosi_hi, 4);
    chk("m3_mosi_first_hi", last_first_hi, 62);
    wait_idle(20, ok);
    tick();
    chk("m3_sck_idle_post", SCK, 1);

    // Round-robin with both requests held
    loop_en = 1'b1; CPK = 1'b0; CPH = 1'b0;
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    DATA0 = 16'h1234; DATA1 = 16'h5678;
    exp_data[0] = 16'h1234; exp_data[1] = 16'h5678;
    exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0; exp_id[3] = 1;
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(40, who);
      chk($sformatf("rr_gnt%0d", i), who, exp_id[i]);
      wait_rvalid(200, ok);
      chk($sformatf("rr_rvalid%0d", i), ok, 1);
      chk($sformatf("rr_rid%0d", i), RID, exp_id[i]);
      chk($sformatf("rr_rdata%0d", i), RDATA, exp_data[exp_id[i]]);
      if (i > 0) chk($sformatf("rr_cs_high%0d", i), last_cs_high, 4);
      if (i == 3) begin
        REQ0 = 1'b0; REQ1 = 1'b0;
      end
    end
    wait_idle(20, ok);
    chk("rr_idle", ok, 1);
    tick(3);

    // Reset on the 5th leading edge of a mode-0 frame
    DATA0 = 16'h0F0F; REQ0 = 1'b1;
    wait_gnt(20, who);
    chk("mr_gnt_first", who, 0);
    REQ0 = 1'b0;
    rv_save = rv_cnt;
    tick(3);
    REQ1 = 1'b1; REQ0 = 1'b1;
    tick(15);
    RESET = 1'b0;
    tick();
    chk("mr_cs", CS, 1);
    chk("mr_busy", BUSY, 0);
    chk("mr_mosi", MOSI, 0);
    chk("mr_gnt", {GNT0, GNT1}, 0);
    chk("mr_sck", SCK, 0);
    RESET = 1'b1;
    wait_gnt(20, who);
    chk("mr_regrant", who, 0);
    chk("mr_no_rvalid", rv_cnt, rv_save);
    REQ0 = 1'b0;
    wait_rvalid(200, ok);
    chk("mr_rid0", RID, 0);
    chk("mr_rdata0", RDATA, 16'h0F0F);
    wait_gnt(40, who);
    chk("mr_gnt_pending", who, 1);
    REQ1 = 1'b0;
    wait_rvalid(200, ok);
    chk("mr_rid1", RID, 1);
    chk("mr_rdata1", RDATA, 16'h5678);
    wait_idle(20, ok);
    tick(2);

    // CPK/CPH changed mid-frame
    DATA0 = 16'h3C5A; REQ0 = 1'b1;
    wait_gnt(20, who);
    chk("cfg_gnt", who, 0);
    REQ0 = 1'b0;
    tick(10);
    CPK = 1'b1; CPH = 1'b1;
    wait_rvalid(200, ok);
    chk("cfg_rvalid", ok, 1);
    chk("cfg_rdata", RDATA, 16'h3C5A);
    chk("cfg_sck_gap0", SCK, 0);
    tick();
    chk("cfg_sck_gap1", SCK, 0);
    chk("cfg_sck_rises", last_rises, 16);
    tick();
    chk("cfg_busy_idle", BUSY, 0);
    chk("cfg_sck_idle0", SCK, 0);
    tick();
    chk("cfg_sck_idle1", SCK, 1);

    // One-cycle REQ1 pulse while busy
    CPK = 1'b0; CPH = 1'b0;
    tick(2);
    DATA0 = 16'h8001; REQ0 = 1'b1;
    wait_gnt(20, who);
    chk("wd_gnt", who, 0);
    REQ0 = 1'b0;
    tick(5);
    g1_save = g1_cnt;
    rv_save = rv_cnt;
    REQ1 = 1'b1;
    tick();
    REQ1 = 1'b0;
    wait_rvalid(200, ok);
    chk("wd_rdata", RDATA, 16'h8001);
    tick(12);
    chk("wd_no_gnt1", g1_cnt, g1_save);
    chk("wd_one_frame", rv_cnt, rv_save + 1);
    chk("wd_busy", BUSY, 0);
    chk("wd_cs", CS, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
